// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter: FSM state
// encoding, slave-select codes and packed-slice widths.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_GAP     = 2'd3
  } arb_state_e;

  localparam int SLV_W = 2;

  localparam logic [SLV_W-1:0] SLV_NONE = 2'd0;
  localparam logic [SLV_W-1:0] SLV_0    = 2'd1;
  localparam logic [SLV_W-1:0] SLV_1    = 2'd2;
  localparam logic [SLV_W-1:0] SLV_2    = 2'd3;

  // Counter width able to hold 0..max(a,b)
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: lowest set request strictly above ptr,
// wrapping to the lowest set request overall.
module spi_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] above;
  logic [N-1:0] masked;

  always_comb begin
    above = '0;
    for (int i = 0; i < N; i++) begin
      above[i] = (IW'(i) > ptr);
    end
    masked = req & above;
    any    = |req;
    idx    = '0;
    gnt    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    // A hit above the pointer overrides the wrapped choice
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) idx = IW'(i);
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Optional macro SPI_ARB_PRIO0_EN gives requester 0 strict priority.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [SLV_W*NUM_REQ-1:0]  req_slave,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      m_start,
  output logic [SLV_W-1:0]          m_slave_select,
  output logic [DATA_W-1:0]         m_data_to_send,
  input  logic [DATA_W-1:0]         m_data_received,
  output logic [1:0]                dbg_state
);

  // Handshake: req is a level held until grant; operands are sampled only on
  // the grant edge; done pulses exactly once per grant (with err if rejected).

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(BIT_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  win_q, win_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic [SLV_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   tx_q, tx_d;

  logic [NUM_REQ-1:0]  req_eff;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic [SLV_W-1:0]    pick_slave;
  logic [DATA_W-1:0]   pick_byte;

`ifdef SPI_ARB_PRIO0_EN
  // Requester 0 preempts the rotation; the others keep round-robin order
  always_comb req_eff = req[0] ? {{(NUM_REQ-1){1'b0}}, 1'b1} : req;
`else
  always_comb req_eff = req;
`endif

  spi_rr_picker #(
    .N  (NUM_REQ),
    .IW (PTR_W)
  ) u_picker (
    .req (req_eff),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_slave = req_slave[SLV_W*pick_idx +: SLV_W];
  assign pick_byte  = req_data[DATA_W*pick_idx +: DATA_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    rsp_d   = rsp_q;
    start_d = start_q;
    sel_d   = sel_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d   = pick_gnt;
          grant_d = pick_gnt;
`ifdef SPI_ARB_PRIO0_EN
          if (!pick_gnt[0]) ptr_d = pick_idx;
`else
          ptr_d = pick_idx;
`endif
          cnt_d = '0;
          if (pick_slave != SLV_NONE) begin
            state_d = ST_XFER;
            sel_d   = pick_slave;
            tx_d    = pick_byte;
            start_d = 1'b1;
          end else begin
            state_d = ST_GAP;
            done_d  = pick_gnt;
            err_d   = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (cnt_q == BIT_LAST) begin
          start_d = 1'b0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Select held one extra cycle: the master updates RX on negedge
        rsp_d   = m_data_received;
        done_d  = win_q;
        sel_d   = SLV_NONE;
        cnt_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rsp_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      sel_q   <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign err            = err_q;
  assign rsp_data       = rsp_q;
  assign busy           = busy_q;
  assign m_start        = start_q;
  assign m_slave_select = sel_q;
  assign m_data_to_send = tx_q;
  assign dbg_state      = state_q;

endmodule
